divider_feeder: RTL and testbench

Request/response front end for the combinational `divider` block. It buffers operand pairs from an upstream valid/ready source in a small FIFO and issues one pair per operation to the divider. It captures the divider's quotient/remainder into a registered response held under valid/ready, and resolves divide-by-zero without enabling the divider. It sits between the datapath producer and the `divider` instance, owning both its input and its output side.

---
 rtl/divider_feeder_if.sv | 59 +++++
 rtl/divider_feeder.sv | 158 +++++++++++++++
 tb/tb_divider_feeder.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/divider_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module      : divider_feeder_if
//  Description : Request, divider-side and response signals of the
//                divider_feeder grouped as one bundle. The slave modport
//                is the feeder's view. The master modport is the view of
//                the surrounding logic: producer, divider and consumer.
//  Revision    : 1.0  initial release
// ============================================================================
interface divider_feeder_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;

    // upstream request
    logic                  req_valid_in;
    logic                  req_ready_out;
    logic [DATA_WIDTH-1:0] req_numerator_in;
    logic [DATA_WIDTH-1:0] req_denominator_in;

    // attached combinational divider
    logic [DATA_WIDTH-1:0] div_numerator_out;
    logic [DATA_WIDTH-1:0] div_denominator_out;
    logic                  div_enable_out;
    logic [DATA_WIDTH-1:0] div_quotient_in;
    logic [DATA_WIDTH-1:0] div_remainder_in;

    // downstream response
    logic                  rsp_valid_out;
    logic                  rsp_ready_in;
    logic [DATA_WIDTH-1:0] rsp_quotient_out;
    logic [DATA_WIDTH-1:0] rsp_remainder_out;
    logic                  rsp_div_by_zero_out;

    // status
    logic [c_CNT_W-1:0]    fifo_count_out;

    modport slave (
        input  req_valid_in, req_numerator_in, req_denominator_in,
        output req_ready_out,
        output div_numerator_out, div_denominator_out, div_enable_out,
        input  div_quotient_in, div_remainder_in,
        output rsp_valid_out, rsp_quotient_out, rsp_remainder_out, rsp_div_by_zero_out,
        input  rsp_ready_in,
        output fifo_count_out
    );

    modport master (
        output req_valid_in, req_numerator_in, req_denominator_in,
        input  req_ready_out,
        input  div_numerator_out, div_denominator_out, div_enable_out,
        output div_quotient_in, div_remainder_in,
        input  rsp_valid_out, rsp_quotient_out, rsp_remainder_out, rsp_div_by_zero_out,
        output rsp_ready_in,
        input  fifo_count_out
    );
endinterface
`default_nettype wire

// File: rtl/divider_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : divider_feeder
//  Description : Buffers operand pairs in a small FIFO and presents one pair
//                per operation to a combinational divider. It captures the
//                quotient and remainder into a response register that is
//                held under valid/ready. A zero divisor is answered locally
//                (all-ones quotient, remainder = numerator, flag set), and the
//                divider is not enabled for it.
//  Revision    : 1.0  initial release
// ============================================================================
module divider_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic         clk_in,
    input  wire logic         rst_n_in,
    divider_feeder_if.slave   bus
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_ENT_W = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    // request FIFO storage and bookkeeping
    logic [c_ENT_W-1:0]      r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]      r_wr_ptr;
    logic [c_PTR_W-1:0]      r_rd_ptr;
    logic [c_CNT_W-1:0]      r_count;

    // registered response
    logic [DATA_WIDTH-1:0]   r_rsp_quotient;
    logic [DATA_WIDTH-1:0]   r_rsp_remainder;
    logic                    r_rsp_div_by_zero;

    logic                    w_full;
    logic                    w_req_ready;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_issue;
    logic [DATA_WIDTH-1:0]   w_head_num;
    logic [DATA_WIDTH-1:0]   w_head_den;
    logic                    w_den_zero;

    // Ready is derived from the registered occupancy only, so a pop in the
    // same cycle never opens a slot early; reset holds it low.
    assign w_full      = (r_count == c_CNT_W'(FIFO_DEPTH));
    assign w_req_ready = !w_full && rst_n_in;
    assign w_push      = bus.req_valid_in && w_req_ready;
    assign w_pop       = (r_state == S_ISSUE);

    assign w_head_num  = r_mem[r_rd_ptr][c_ENT_W-1:DATA_WIDTH];
    assign w_head_den  = r_mem[r_rd_ptr][DATA_WIDTH-1:0];
    assign w_den_zero  = (w_head_den == '0);

    // The divider sees operands only during the single ISSUE cycle.
    assign w_issue     = (r_state == S_ISSUE) && rst_n_in;

    // FIFO storage write; contents need no reset because occupancy gates reads
    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.req_numerator_in, bus.req_denominator_in};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at a power-of-two depth
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: IDLE waits for work, ISSUE lasts one cycle, RESP holds until accepted
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready_in) begin
                    w_state_nxt = (r_count != '0) ? S_ISSUE : S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Response capture at the end of ISSUE; a zero divisor bypasses the divider
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_rsp_quotient    <= '0;
            r_rsp_remainder   <= '0;
            r_rsp_div_by_zero <= 1'b0;
        end else if (r_state == S_ISSUE) begin
            if (w_den_zero) begin
                r_rsp_quotient    <= '1;
                r_rsp_remainder   <= w_head_num;
                r_rsp_div_by_zero <= 1'b1;
            end else begin
                r_rsp_quotient    <= bus.div_quotient_in;
                r_rsp_remainder   <= bus.div_remainder_in;
                r_rsp_div_by_zero <= 1'b0;
            end
        end
    end

    assign bus.req_ready_out       = w_req_ready;
    assign bus.div_numerator_out   = w_issue ? w_head_num : '0;
    assign bus.div_denominator_out = w_issue ? w_head_den : '0;
    assign bus.div_enable_out      = w_issue && !w_den_zero;
    assign bus.rsp_valid_out       = (r_state == S_RESP);
    assign bus.rsp_quotient_out    = r_rsp_quotient;
    assign bus.rsp_remainder_out   = r_rsp_remainder;
    assign bus.rsp_div_by_zero_out = r_rsp_div_by_zero;
    assign bus.fifo_count_out      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_divider_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_divider_feeder
//  Description : Directed self-checking bench for divider_feeder with a
//                behavioural divider attached to the divider-side port.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_divider_feeder;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   en_cnt = 0;
    logic [16:0] rq [$];   // {flag, quotient, remainder} of each accepted response
    int          rc [$];   // cycle number of each accepted response

    // pointer-wrap vectors with hand-computed results
    logic [7:0] wn [12] = '{8'd200, 8'd255, 8'd7,   8'd0, 8'd123, 8'd50, 8'd250, 8'd99, 8'd17,  8'd128, 8'd77, 8'd64};
    logic [7:0] wd [12] = '{8'd9,   8'd16,  8'd0,   8'd5, 8'd123, 8'd51, 8'd1,   8'd10, 8'd0,   8'd3,   8'd8,  8'd64};
    logic [7:0] wq [12] = '{8'd22,  8'd15,  8'hFF,  8'd0, 8'd1,   8'd0,  8'd250, 8'd9,  8'hFF,  8'd42,  8'd9,  8'd1};
    logic [7:0] wr [12] = '{8'd2,   8'd15,  8'd7,   8'd0, 8'd0,   8'd50, 8'd0,   8'd9,  8'd17,  8'd2,   8'd5,  8'd0};
    logic       wf [12] = '{1'b0,   1'b0,   1'b1,   1'b0, 1'b0,   1'b0,  1'b0,   1'b0,  1'b1,   1'b0,   1'b0,  1'b0};

    divider_feeder_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

    divider_feeder #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // behavioural divider; recognisable junk when not enabled
    always_comb begin
        bus.div_quotient_in  = 8'hA5;
        bus.div_remainder_in = 8'h5A;
        if (bus.div_enable_out && bus.div_denominator_out != 8'd0) begin
            bus.div_quotient_in  = bus.div_numerator_out / bus.div_denominator_out;
            bus.div_remainder_in = bus.div_numerator_out % bus.div_denominator_out;
        end
    end

    // cycle counter, enable counter, response collector
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.div_enable_out) en_cnt <= en_cnt + 1;
        if (rst_n && bus.rsp_valid_out && bus.rsp_ready_in) begin
            rq.push_back({bus.rsp_div_by_zero_out, bus.rsp_quotient_out, bus.rsp_remainder_out});
            rc.push_back(cyc);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic push(input logic [7:0] n, input logic [7:0] d);
        int k = 0;
        bus.req_valid_in       = 1'b1;
        bus.req_numerator_in   = n;
        bus.req_denominator_in = d;
        while (bus.req_ready_out !== 1'b1 && k < 200) begin @(negedge clk); k++; end
        total++; if (k >= 200) begin bad++; $display("FAIL push_accept n=%0d d=%0d: ready never rose, want accepted", n, d); end
        else @(posedge clk);
        #1;
        bus.req_valid_in = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        int k = 0;
        while (rq.size() < target && k < 300) begin @(negedge clk); k++; end
        total++; if (rq.size() < target) begin bad++; $display("FAIL rsp_wait got=%0d want=%0d responses", rq.size(), target); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid_in = 1'b1; bus.req_numerator_in = 8'd5; bus.req_denominator_in = 8'd1;
        bus.rsp_ready_in = 1'b0;
        @(negedge clk);
        total++; if (bus.req_ready_out !== 1'b0) begin bad++; $display("FAIL reset_req_ready got=%b want=0", bus.req_ready_out); end
        total++; if (bus.rsp_valid_out !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", bus.rsp_valid_out); end
        total++; if (bus.fifo_count_out !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus.fifo_count_out); end
        total++; if ({bus.rsp_quotient_out, bus.rsp_remainder_out, bus.rsp_div_by_zero_out} !== 17'd0) begin bad++; $display("FAIL reset_rsp_data got=%h/%h/%b want=0/0/0", bus.rsp_quotient_out, bus.rsp_remainder_out, bus.rsp_div_by_zero_out); end
        total++; if ({bus.div_numerator_out, bus.div_denominator_out, bus.div_enable_out} !== 17'd0) begin bad++; $display("FAIL reset_div got=%h/%h/%b want=0/0/0", bus.div_numerator_out, bus.div_denominator_out, bus.div_enable_out); end
        @(negedge clk);
        rst_n = 1'b1; bus.req_valid_in = 1'b0;
        @(negedge clk);
        total++; if (bus.req_ready_out !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b want=1", bus.req_ready_out); end
        total++; if (bus.fifo_count_out !== 3'd0) begin bad++; $display("FAIL post_reset_count got=%0d want=0", bus.fifo_count_out); end
    endtask

    task automatic test_single();
        int e0, b;
        bus.rsp_ready_in = 1'b1;
        e0 = en_cnt; b = rq.size();
        push(8'd100, 8'd7);
        @(negedge clk); // cycle 1
        total++; if (bus.rsp_valid_out !== 1'b0 || bus.div_enable_out !== 1'b0) begin bad++; $display("FAIL single_c1 valid/en got=%b/%b want=0/0", bus.rsp_valid_out, bus.div_enable_out); end
        @(negedge clk); // cycle 2: ISSUE
        total++; if (bus.div_enable_out !== 1'b1 || bus.div_numerator_out !== 8'd100 || bus.div_denominator_out !== 8'd7) begin bad++; $display("FAIL single_issue en/n/d got=%b/%0d/%0d want=1/100/7", bus.div_enable_out, bus.div_numerator_out, bus.div_denominator_out); end
        total++; if (bus.rsp_valid_out !== 1'b0) begin bad++; $display("FAIL single_c2_valid got=%b want=0", bus.rsp_valid_out); end
        @(negedge clk); // cycle 3: RESP
        total++; if (bus.rsp_valid_out !== 1'b1) begin bad++; $display("FAIL single_c3_valid got=%b want=1", bus.rsp_valid_out); end
        total++; if (bus.rsp_quotient_out !== 8'd14 || bus.rsp_remainder_out !== 8'd2 || bus.rsp_div_by_zero_out !== 1'b0) begin bad++; $display("FAIL single_data got=%0d/%0d/%b want=14/2/0", bus.rsp_quotient_out, bus.rsp_remainder_out, bus.rsp_div_by_zero_out); end
        @(negedge clk);
        total++; if (bus.rsp_valid_out !== 1'b0) begin bad++; $display("FAIL single_c4_valid got=%b want=0", bus.rsp_valid_out); end
        total++; if (en_cnt - e0 !== 1) begin bad++; $display("FAIL single_enable_cycles got=%0d want=1", en_cnt - e0); end
        total++; if (rq.size() !== b + 1) begin bad++; $display("FAIL single_rsp_count got=%0d want=%0d", rq.size(), b + 1); end
    endtask

    task automatic test_div_zero();
        int e0;
        bus.rsp_ready_in = 1'b1;
        e0 = en_cnt;
        push(8'd37, 8'd0);
        @(negedge clk);
        @(negedge clk); // ISSUE
        total++; if (bus.div_enable_out !== 1'b0 || bus.div_numerator_out !== 8'd37 || bus.div_denominator_out !== 8'd0) begin bad++; $display("FAIL dz_issue en/n/d got=%b/%0d/%0d want=0/37/0", bus.div_enable_out, bus.div_numerator_out, bus.div_denominator_out); end
        @(negedge clk); // RESP
        total++; if (bus.rsp_valid_out !== 1'b1) begin bad++; $display("FAIL dz_valid got=%b want=1", bus.rsp_valid_out); end
        total++; if (bus.rsp_quotient_out !== 8'hFF || bus.rsp_remainder_out !== 8'd37 || bus.rsp_div_by_zero_out !== 1'b1) begin bad++; $display("FAIL dz_data got=%h/%0d/%b want=ff/37/1", bus.rsp_quotient_out, bus.rsp_remainder_out, bus.rsp_div_by_zero_out); end
        @(negedge clk);
        total++; if (en_cnt !== e0) begin bad++; $display("FAIL dz_enable_cycles got=%0d want=0", en_cnt - e0); end
    endtask

    task automatic test_backpressure();
        int b;
        logic [7:0] eq [6] = '{8'd3, 8'd3, 8'd4, 8'd4, 8'd4, 8'd5};
        logic [7:0] er [6] = '{8'd1, 8'd2, 8'd0, 8'd1, 8'd2, 8'd0};
        bus.rsp_ready_in = 1'b0;
        b = rq.size();
        for (int n = 10; n < 15; n++) push(8'(n), 8'd3);
        @(negedge clk);
        total++; if (bus.fifo_count_out !== 3'd4 || bus.req_ready_out !== 1'b0) begin bad++; $display("FAIL bp_full count/ready got=%0d/%b want=4/0", bus.fifo_count_out, bus.req_ready_out); end
        for (int i = 0; i < 3; i++) begin
            total++; if (bus.rsp_valid_out !== 1'b1 || bus.rsp_quotient_out !== 8'd3 || bus.rsp_remainder_out !== 8'd1) begin bad++; $display("FAIL bp_stable[%0d] got=%b/%0d/%0d want=1/3/1", i, bus.rsp_valid_out, bus.rsp_quotient_out, bus.rsp_remainder_out); end
            @(negedge clk);
        end
        bus.rsp_ready_in = 1'b1;
        push(8'd15, 8'd3);
        wait_rsp(b + 6);
        for (int i = 0; i < 6; i++) begin
            if (rq.size() > b + i) begin
                total++; if (rq[b+i] !== {1'b0, eq[i], er[i]}) begin bad++; $display("FAIL bp_rsp[%0d] got=%h want=%h", i, rq[b+i], {1'b0, eq[i], er[i]}); end
                if (i > 0) begin
                    total++; if (rc[b+i] - rc[b+i-1] !== 2) begin bad++; $display("FAIL bp_spacing[%0d] got=%0d want=2 cycles", i, rc[b+i] - rc[b+i-1]); end
                end
            end
        end
    endtask

    task automatic test_wrap();
        int idx = 0;
        int k = 0;
        int b;
        logic acc;
        b = rq.size();
        while (rq.size() < b + 12 && k < 600) begin
            bus.rsp_ready_in = 1'($urandom_range(0, 1));
            bus.req_valid_in = (idx < 12);
            if (idx < 12) begin bus.req_numerator_in = wn[idx]; bus.req_denominator_in = wd[idx]; end
            acc = bus.req_valid_in && bus.req_ready_out;
            @(posedge clk);
            if (acc) idx++;
            @(negedge clk);
            k++;
        end
        bus.req_valid_in = 1'b0;
        bus.rsp_ready_in = 1'b1;
        total++; if (rq.size() < b + 12) begin bad++; $display("FAIL wrap_timeout got=%0d want=%0d responses", rq.size() - b, 12); end
        for (int i = 0; i < 12; i++) begin
            if (rq.size() > b + i) begin
                total++; if (rq[b+i] !== {wf[i], wq[i], wr[i]}) begin bad++; $display("FAIL wrap_rsp[%0d] got=%h want=%h", i, rq[b+i], {wf[i], wq[i], wr[i]}); end
            end
        end
        repeat (6) @(negedge clk);
        total++; if (rq.size() !== b + 12) begin bad++; $display("FAIL wrap_no_dup got=%0d want=12 responses", rq.size() - b); end
    endtask

    task automatic test_reset_mid();
        int b;
        bus.rsp_ready_in = 1'b0;
        b = rq.size();
        for (int n = 1; n <= 4; n++) push(8'(n), 8'd1);
        @(negedge clk);
        total++; if (bus.fifo_count_out !== 3'd3 || bus.rsp_valid_out !== 1'b1) begin bad++; $display("FAIL rm_setup count/valid got=%0d/%b want=3/1", bus.fifo_count_out, bus.rsp_valid_out); end
        rst_n = 1'b0;
        #1;
        total++; if (bus.req_ready_out !== 1'b0) begin bad++; $display("FAIL rm_ready_in_reset got=%b want=0", bus.req_ready_out); end
        @(negedge clk);
        rst_n = 1'b1;
        total++; if (bus.fifo_count_out !== 3'd0 || bus.rsp_valid_out !== 1'b0) begin bad++; $display("FAIL rm_cleared count/valid got=%0d/%b want=0/0", bus.fifo_count_out, bus.rsp_valid_out); end
        total++; if ({bus.rsp_quotient_out, bus.rsp_remainder_out, bus.rsp_div_by_zero_out, bus.div_enable_out, bus.div_numerator_out} !== 26'd0) begin bad++; $display("FAIL rm_outputs got=%h/%h/%b/%b/%h want=all 0", bus.rsp_quotient_out, bus.rsp_remainder_out, bus.rsp_div_by_zero_out, bus.div_enable_out, bus.div_numerator_out); end
        bus.rsp_ready_in = 1'b1;
        repeat (5) @(negedge clk);
        total++; if (bus.rsp_valid_out !== 1'b0 || rq.size() !== b) begin bad++; $display("FAIL rm_stale valid/responses got=%b/%0d want=0/0", bus.rsp_valid_out, rq.size() - b); end
        push(8'd9, 8'd4);
        wait_rsp(b + 1);
        if (rq.size() > b) begin
            total++; if (rq[b] !== {1'b0, 8'd2, 8'd1}) begin bad++; $display("FAIL rm_next_rsp got=%h want=%h", rq[b], {1'b0, 8'd2, 8'd1}); end
        end
        repeat (3) @(negedge clk);
        total++; if (rq.size() !== b + 1) begin bad++; $display("FAIL rm_rsp_count got=%0d want=1", rq.size() - b); end
    endtask

    task automatic test_full_simul();
        int b;
        logic [7:0] eq [6] = '{8'd5, 8'd5, 8'd5, 8'd5, 8'd6, 8'd20};
        logic [7:0] er [6] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd0};
        bus.rsp_ready_in = 1'b0;
        b = rq.size();
        for (int n = 20; n < 25; n++) push(8'(n), 8'd4);
        @(negedge clk);
        total++; if (bus.fifo_count_out !== 3'd4 || bus.req_ready_out !== 1'b0 || bus.rsp_valid_out !== 1'b1) begin bad++; $display("FAIL fs_setup count/ready/valid got=%0d/%b/%b want=4/0/1", bus.fifo_count_out, bus.req_ready_out, bus.rsp_valid_out); end
        bus.req_valid_in = 1'b1; bus.req_numerator_in = 8'd200; bus.req_denominator_in = 8'd10;
        bus.rsp_ready_in = 1'b1;
        @(negedge clk); // ISSUE with FIFO full and a request pending
        total++; if (bus.div_enable_out !== 1'b1 || bus.req_ready_out !== 1'b0 || bus.fifo_count_out !== 3'd4) begin bad++; $display("FAIL fs_issue en/ready/count got=%b/%b/%0d want=1/0/4", bus.div_enable_out, bus.req_ready_out, bus.fifo_count_out); end
        bus.rsp_ready_in = 1'b0;
        @(negedge clk);
        total++; if (bus.fifo_count_out !== 3'd3 || bus.req_ready_out !== 1'b1) begin bad++; $display("FAIL fs_after_pop count/ready got=%0d/%b want=3/1", bus.fifo_count_out, bus.req_ready_out); end
        @(negedge clk);
        total++; if (bus.fifo_count_out !== 3'd4 || bus.req_ready_out !== 1'b0) begin bad++; $display("FAIL fs_refill count/ready got=%0d/%b want=4/0", bus.fifo_count_out, bus.req_ready_out); end
        bus.req_valid_in = 1'b0;
        bus.rsp_ready_in = 1'b1;
        wait_rsp(b + 6);
        for (int i = 0; i < 6; i++) begin
            if (rq.size() > b + i) begin
                total++; if (rq[b+i] !== {1'b0, eq[i], er[i]}) begin bad++; $display("FAIL fs_rsp[%0d] got=%h want=%h", i, rq[b+i], {1'b0, eq[i], er[i]}); end
            end
        end
    endtask

    initial begin
        bus.req_valid_in       = 1'b0;
        bus.req_numerator_in   = 8'd0;
        bus.req_denominator_in = 8'd0;
        bus.rsp_ready_in       = 1'b0;
        test_reset();
        test_single();
        test_div_zero();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_full_simul();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
